// File: rtl/spi_mem_fetch_pkg.sv
// spi_fetch_pkg: shared types and frame constants for the SPI memory fetch engine.
// Holds the FSM state encoding and the bit counts of a full READ frame
// (cmd + 16-bit addr + data byte) and of the data-only continuation.
package spi_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE   = 2'd2,
    CS_GAP = 2'd3
  } spi_fetch_state_t;

  localparam int SPI_FRAME_BITS = 32;
  localparam int SPI_DATA_BITS  = 8;

endpackage

// File: rtl/spi_mem_fetch_sclk_gen.sv
// spi_sclk_gen: SCLK divider for the SPI fetch engine.
// The divider is a down-counter that toggles sclk when it reaches zero and
// reloads CLK_DIV-1. While disabled it is held reloaded with sclk low, so
// the first rising edge lands CLK_DIV cycles after enable goes high.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   en   in  run the divider (high only while shifting)
//   sclk out SPI clock, idle low
//   rise out strobe: sclk goes high at this clk edge
//   fall out strobe: sclk goes low at this clk edge
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_tc;

  assign div_tc = en && (div_cnt == '0);
  assign rise   = div_tc && !sclk;
  assign fall   = div_tc && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= DIV_LAST;
      sclk    <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= DIV_LAST;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_mem_fetch.sv
// spi_mem_fetch: SPI (mode 0) READ engine serving the CU fetch handshake.
// On req it sends {CMD_READ, addr, 8'h00} MSB-first, samples miso on every
// sclk rise and presents the last received byte on data with done held
// until req drops. Full transfer latency is 64*CLK_DIV cycles.
// Optional feature, macro SPI_SEQ_EN: keeps cs_n low after a read; a request
// for the next address shifts only the data byte (16*CLK_DIV), any other
// address first raises cs_n for 2*CLK_DIV cycles (CS_GAP) then runs a full frame.
// Ports:
//   clk  in  system clock          rst  in  async active-high reset
//   req  in  level fetch request   addr in  byte address, sampled on accept
//   done out transfer complete     data out last byte read
//   busy out accept..done          sclk/cs_n/mosi out, miso in: SPI bus
//
// state  | meaning
// IDLE   | waiting for req
// SHIFT  | sclk running, frame shifting out/in
// DONE   | data valid, done held until req drops
// CS_GAP | cs_n high before restarting a non-sequential frame
module spi_mem_fetch
  import spi_fetch_pkg::*;
#(
  parameter int          CLK_DIV  = 2,
  parameter int          ADDR_W   = 16,
  parameter logic [7:0]  CMD_READ = 8'h03
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic [7:0]        data,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int GAP_W = $clog2(2 * CLK_DIV) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 1);

  spi_fetch_state_t state, state_nxt;

  logic [SPI_FRAME_BITS-1:0] sr;
  logic [5:0]                bit_cnt;
  logic [5:0]                frame_last;
  logic [ADDR_W-1:0]         addr_q;
  logic [GAP_W-1:0]          gap_cnt;
  logic                      short_q;
  logic                      sclk_rise, sclk_fall;
  logic                      frame_end;
  logic                      need_gap, seq_hit;

`ifdef SPI_SEQ_EN
  logic              seq_valid;
  logic [ADDR_W-1:0] next_addr;

  assign seq_hit  = seq_valid && (addr == next_addr);
  assign need_gap = seq_valid && (addr != next_addr);
`else
  assign seq_hit  = 1'b0;
  assign need_gap = 1'b0;
`endif

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state == SHIFT),
    .sclk (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // bit_cnt counts rises, so the last fall of a frame sees the full count
  assign frame_last = short_q ? 6'(SPI_DATA_BITS) : 6'(SPI_FRAME_BITS);
  assign frame_end  = sclk_fall && (bit_cnt == frame_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = need_gap ? CS_GAP : SHIFT;
      SHIFT:   if (frame_end) state_nxt = DONE;
      DONE:    if (!req) state_nxt = IDLE;
      CS_GAP:  if (gap_cnt == '0) state_nxt = SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      addr_q  <= '0;
      gap_cnt <= '0;
      short_q <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      data    <= 8'h00;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
`ifdef SPI_SEQ_EN
      seq_valid <= 1'b0;
      next_addr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            busy    <= 1'b1;
            bit_cnt <= '0;
            short_q <= seq_hit;
            if (need_gap) begin
              cs_n    <= 1'b1;
              gap_cnt <= GAP_LAST;
            end else if (seq_hit) begin
              // continuation: memory streams the next byte, nothing to send
              sr   <= '0;
              mosi <= 1'b0;
              cs_n <= 1'b0;
            end else begin
              sr   <= {CMD_READ, addr, 8'h00};
              mosi <= CMD_READ[7];
              cs_n <= 1'b0;
            end
          end
        end
        CS_GAP: begin
          if (gap_cnt == '0) begin
            sr   <= {CMD_READ, addr_q, 8'h00};
            mosi <= CMD_READ[7];
            cs_n <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            sr      <= {sr[SPI_FRAME_BITS-2:0], miso};
            bit_cnt <= bit_cnt + 6'd1;
          end
          if (frame_end) begin
            data <= sr[SPI_DATA_BITS-1:0];
            done <= 1'b1;
            busy <= 1'b0;
            mosi <= 1'b0;
`ifdef SPI_SEQ_EN
            seq_valid <= 1'b1;
            next_addr <= addr_q + ADDR_W'(1);
`else
            cs_n <= 1'b1;
`endif
          end else if (sclk_fall) begin
            mosi <= sr[SPI_FRAME_BITS-1];
          end
        end
        DONE: begin
          if (!req) done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_fetch.sv
// Bench for spi_mem_fetch: two instances (CLK_DIV=1 and CLK_DIV=3), each with
// a serial memory model that streams a chosen byte on miso and records mosi.
// Table of directed transfers plus hand-written handshake/reset/sequential cases.
module tb_spi_mem_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req      [2];
  logic [15:0] addr_v   [2];
  logic [7:0]  mem_byte [2];

  wire        done_w [2];
  wire [7:0]  data_w [2];
  wire        busy_w [2];
  wire        sclk_w [2];
  wire        cs_n_w [2];
  wire        mosi_w [2];
  wire        miso_w [2];
  wire [15:0] rcnt_w [2];
  wire [31:0] cap_w  [2];

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef SPI_SEQ_EN
  logic        sv [2];
  logic [15:0] na [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DIV = (g == 0) ? 1 : 3;
    logic [15:0] rcnt;
    logic [31:0] cap;
    logic [7:0]  seq_cnt;

    spi_mem_fetch #(.CLK_DIV(DIV), .ADDR_W(16), .CMD_READ(8'h03)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req[g]),
      .addr (addr_v[g]),
      .done (done_w[g]),
      .data (data_w[g]),
      .busy (busy_w[g]),
      .sclk (sclk_w[g]),
      .cs_n (cs_n_w[g]),
      .mosi (mosi_w[g]),
      .miso (miso_w[g])
    );

    always @(posedge sclk_w[g] or posedge rst) begin
      if (rst) begin
        rcnt <= '0;
        cap  <= '0;
      end else begin
        rcnt <= rcnt + 16'd1;
        cap  <= {cap[30:0], mosi_w[g]};
      end
    end

    // rises since cs_n fell; the byte repeats every 8 rises so both the
    // full frame (rises 25..32) and continuation bytes see bit 7 first
    always @(posedge sclk_w[g] or posedge cs_n_w[g]) begin
      if (cs_n_w[g]) seq_cnt <= '0;
      else           seq_cnt <= seq_cnt + 8'd1;
    end

    assign miso_w[g] = mem_byte[g][~seq_cnt[2:0]];
    assign rcnt_w[g] = rcnt;
    assign cap_w[g]  = cap;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
`ifdef SPI_SEQ_EN
    sv[0] = 1'b0; sv[1] = 1'b0;
`endif
  endtask

  task automatic check_reset_state(input int g);
    chk($sformatf("rst_done%0d", g), done_w[g], 0);
    chk($sformatf("rst_busy%0d", g), busy_w[g], 0);
    chk($sformatf("rst_csn%0d", g),  cs_n_w[g], 1);
    chk($sformatf("rst_sclk%0d", g), sclk_w[g], 0);
    chk($sformatf("rst_data%0d", g), data_w[g], 0);
  endtask

  // Runs one transfer, leaves req high with done asserted.
  task automatic check_xfer(input int g, input logic [15:0] a, input logic [7:0] b,
                            input logic [7:0] exp_data, input logic [31:0] exp_mosi,
                            input int exp_lat, input int exp_rises);
    int c, gap, n, lat, r0, cs_hi, busy_hi, first_r, second_r;
    logic prev_s;
    logic [31:0] mask;
    c   = (g == 0) ? 1 : 3;
    gap = 0;
`ifdef SPI_SEQ_EN
    if (sv[g] && a != na[g]) gap = 1;
`endif
    @(negedge clk);
    addr_v[g] = a; mem_byte[g] = b; req[g] = 1'b1;
    @(posedge clk); #1;
    r0 = int'(rcnt_w[g]);
    n = 0; lat = -1; cs_hi = 0; busy_hi = 0; first_r = -1; second_r = -1;
    prev_s = sclk_w[g];
    addr_v[g] = ~a;
    while (n < 1000) begin
      if (done_w[g]) begin lat = n; break; end
      if (cs_n_w[g]) cs_hi++;
      if (busy_w[g]) busy_hi++;
      @(posedge clk); #1; n++;
      if (sclk_w[g] && !prev_s) begin
        if (first_r < 0) first_r = n;
        else if (second_r < 0) second_r = n;
      end
      prev_s = sclk_w[g];
    end
    mask = (exp_rises == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    chk($sformatf("lat_%0h", a),    lat, exp_lat + gap * 2 * c);
    chk($sformatf("data_%0h", a),   data_w[g], exp_data);
    chk($sformatf("rises_%0h", a),  int'(rcnt_w[g]) - r0, exp_rises);
    chk($sformatf("mosi_%0h", a),   cap_w[g] & mask, exp_mosi & mask);
    chk($sformatf("cshi_%0h", a),   cs_hi, gap * 2 * c);
    chk($sformatf("busy_%0h", a),   busy_hi, exp_lat + gap * 2 * c);
    chk($sformatf("busy_end_%0h", a), busy_w[g], 0);
    chk($sformatf("rise1_%0h", a),  first_r, c + gap * 2 * c);
    chk($sformatf("period_%0h", a), second_r - first_r, 2 * c);
`ifdef SPI_SEQ_EN
    sv[g] = 1'b1; na[g] = a + 16'd1;
`endif
  endtask

  task automatic release_req(input int g);
    @(negedge clk); req[g] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("done_clear%0d", g), done_w[g], 0);
  endtask

  typedef struct {
    int          g;
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  exp_data;
    logic [31:0] exp_mosi;
    int          exp_lat;
    int          exp_rises;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int hold, seen, n;
    vecs[0] = '{0, 16'h1234, 8'hA5, 8'hA5, 32'h0312_3400,  64, 32};
    vecs[1] = '{1, 16'hFFFF, 8'h3C, 8'h3C, 32'h03FF_FF00, 192, 32};
    vecs[2] = '{0, 16'h0000, 8'hFF, 8'hFF, 32'h0300_0000,  64, 32};
    vecs[3] = '{0, 16'h8001, 8'h00, 8'h00, 32'h0380_0100,  64, 32};
    vecs[4] = '{1, 16'h00A0, 8'h5A, 8'h5A, 32'h0300_A000, 192, 32};

    for (int g = 0; g < 2; g++) begin
      req[g] = 1'b0; addr_v[g] = '0; mem_byte[g] = '0;
    end
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_reset_state(0);
    check_reset_state(1);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      check_xfer(vecs[i].g, vecs[i].a, vecs[i].b, vecs[i].exp_data,
                 vecs[i].exp_mosi, vecs[i].exp_lat, vecs[i].exp_rises);
      release_req(vecs[i].g);
    end

    // handshake: done holds while req stays high, clears one edge after req drops
    check_xfer(0, 16'h2000, 8'hC3, 8'hC3, 32'h0320_0000, 64, 32);
    hold = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done_w[0]) hold++;
    end
    chk("done_hold", hold, 10);
    release_req(0);
    chk("data_after_done", data_w[0], 8'hC3);
    check_xfer(0, 16'h3000, 8'h81, 8'h81, 32'h0330_0000, 64, 32);
    release_req(0);

    // reset while idle with non-zero data
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check_reset_state(0);
    check_reset_state(1);
    clear_model();
    @(negedge clk) rst = 1'b0;

    // reset in the middle of a frame
    @(negedge clk);
    addr_v[0] = 16'h4321; mem_byte[0] = 8'h96; req[0] = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_mid", busy_w[0], 1);
    chk("csn_mid", cs_n_w[0], 0);
    rst = 1'b1;
    #1;
    chk("abort_csn", cs_n_w[0], 1);
    chk("abort_sclk", sclk_w[0], 0);
    chk("abort_busy", busy_w[0], 0);
    chk("abort_done", done_w[0], 0);
    @(negedge clk) req[0] = 1'b0;
    @(negedge clk) rst = 1'b0;
    clear_model();
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done_w[0]) seen++;
    end
    chk("done_after_abort", seen, 0);
    check_xfer(0, 16'h4321, 8'h96, 8'h96, 32'h0343_2100, 64, 32);
    release_req(0);

    // req dropped mid-frame: transfer completes, done pulses once
    @(negedge clk);
    addr_v[1] = 16'h5555; mem_byte[1] = 8'h0F; req[1] = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk) req[1] = 1'b0;
    n = 0;
    while (n < 1000 && !done_w[1]) begin
      @(posedge clk); #1; n++;
    end
    seen = 0;
    repeat (5) begin
      if (done_w[1]) seen++;
      @(posedge clk); #1;
    end
    chk("drop_done_pulse", seen, 1);
    chk("drop_data", data_w[1], 8'h0F);
`ifdef SPI_SEQ_EN
    sv[1] = 1'b1; na[1] = 16'h5556;

    check_xfer(0, 16'h0010, 8'h11, 8'h11, 32'h0300_1000, 64, 32);
    release_req(0);
    chk("seq_csn_idle", cs_n_w[0], 0);
    check_xfer(0, 16'h0011, 8'h22, 8'h22, 32'h0000_0000, 16, 8);
    release_req(0);
    check_xfer(0, 16'h0040, 8'h77, 8'h77, 32'h0300_4000, 64, 32);
    release_req(0);
    check_xfer(1, 16'hFFFF, 8'h44, 8'h44, 32'h03FF_FF00, 192, 32);
    release_req(1);
    check_xfer(1, 16'h0000, 8'hE1, 8'hE1, 32'h0000_0000, 48, 8);
    release_req(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
